rambus_sample_fetcher: RTL and testbench



---
 rtl/rambus_sample_fetcher_if.sv | 23 ++
 rtl/rambus_sample_fetcher.sv | 139 +++++++++++++
 tb/tb_rambus_sample_fetcher.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rambus_sample_fetcher_if.sv
// Read-only Wishbone link between the sample fetcher (master) and the shared OpenRAM bus (slave).
// Carries word addresses; the byte address is formed outside by appending 2'b00.
interface rambus_sample_fetcher_if #(
  parameter int ADDR_W = 8
);
  logic              rambus_wb_cyc_o;
  logic              rambus_wb_stb_o;
  logic              rambus_wb_we_o;
  logic [3:0]        rambus_wb_sel_o;
  logic [ADDR_W-1:0] rambus_wb_adr_o;
  logic              rambus_wb_ack_i;
  logic [31:0]       rambus_wb_dat_i;

  modport master (
    output rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_adr_o,
    input  rambus_wb_ack_i, rambus_wb_dat_i
  );

  modport slave (
    input  rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_adr_o,
    output rambus_wb_ack_i, rambus_wb_dat_i
  );
endinterface

// File: rtl/rambus_sample_fetcher.sv
// Streams 32-bit words from a circular RAM region into a word FIFO and unpacks them into 8-bit samples.
// Optional RAMBUS_TIMEOUT_EN adds a 255-cycle bus watchdog and a sticky timeout_o flag.
module rambus_sample_fetcher #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  enable,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     end_addr,
  rambus_sample_fetcher_if.master bus,
  output logic [7:0]            sample_o,
  output logic                  sample_valid_o,
  input  logic                  sample_ready_i,
  output logic                  wrap_o,
  output logic                  underrun_o
`ifdef RAMBUS_TIMEOUT_EN
  ,
  output logic                  timeout_o
`endif
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FLUSH} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_adr;
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [1:0]        r_byte_idx;
  logic              r_wrap, r_abort;

  logic        w_empty, w_full, w_fire, w_pop, w_push, w_ack, w_abort, w_cyc, w_timeout;
  logic [31:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_fire  = !w_empty && sample_ready_i;
  assign w_pop   = w_fire && (r_byte_idx == 2'd3);
  // Once enable drops mid-cycle the access is still completed, but its data must never land.
  assign w_abort = r_abort || !enable;
  assign w_ack   = (r_state == S_REQ) && bus.rambus_wb_ack_i;
  assign w_push  = w_ack && !w_abort;

`ifdef RAMBUS_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_timeout;

  assign w_timeout = (r_state == S_REQ) && !bus.rambus_wb_ack_i && (r_wdog == 8'd254);
  assign timeout_o = r_timeout;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wdog <= (r_state == S_REQ && w_next == S_REQ) ? r_wdog + 8'd1 : 8'd0;
      if (!enable)        r_timeout <= 1'b0;
      else if (w_timeout) r_timeout <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    w_cyc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!enable)               w_next = S_FLUSH;
        else if (!w_full || w_pop) w_next = S_REQ;
      end
      S_REQ: begin
        w_cyc = 1'b1;
        if (bus.rambus_wb_ack_i || w_timeout) w_next = w_abort ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state    <= S_IDLE;
      r_adr      <= '0;
      r_wrap     <= 1'b0;
      r_abort    <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_byte_idx <= '0;
    end else begin
      r_state <= w_next;
      r_abort <= (r_state == S_REQ) && (w_next == S_REQ) && w_abort;
      r_wrap  <= w_push && (r_adr == end_addr);
      if ((r_state == S_IDLE && !enable) || r_state == S_FLUSH)
        r_adr <= start_addr;
      else if (w_push)
        r_adr <= (r_adr == end_addr) ? start_addr : r_adr + ADDR_W'(1);

      if (r_state == S_FLUSH) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_byte_idx <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
        if (w_fire) r_byte_idx <= r_byte_idx + 2'd1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Word storage carries no reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wptr] <= bus.rambus_wb_dat_i;
  end

  assign w_head         = r_mem[r_rptr];
  assign sample_o       = w_head[{r_byte_idx, 3'b000} +: 8];
  assign sample_valid_o = !w_empty;
  assign wrap_o         = r_wrap;
  assign underrun_o     = enable && sample_ready_i && w_empty;

  assign bus.rambus_wb_cyc_o = w_cyc;
  assign bus.rambus_wb_stb_o = w_cyc;
  assign bus.rambus_wb_we_o  = 1'b0;
  assign bus.rambus_wb_sel_o = 4'hF;
  assign bus.rambus_wb_adr_o = r_adr;
endmodule

// File: tb/tb_rambus_sample_fetcher.sv
// Directed bench for rambus_sample_fetcher: RAM slave model with programmable ack delay,
// table-driven region runs plus hand-written full/flush (and optional timeout) sequences.
module tb_rambus_sample_fetcher;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] st = 8'h10;
  logic [7:0] ea = 8'h11;
  logic [7:0] sample;
  logic       valid, ready = 1'b0, wrap, urun;
`ifdef RAMBUS_TIMEOUT_EN
  logic       tmo;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int dly = 0;
  int wait_cnt = 0;
  bit never_ack = 1'b0;
  bit mon_on = 1'b0;
  bit prev_wrap_exp = 1'b0;
  int n_urun = 0;
  logic [31:0] ram [256];
  logic [7:0]  smp_q[$];
  logic [7:0]  adr_q[$];

  rambus_sample_fetcher_if #(.ADDR_W(8)) bus ();

  rambus_sample_fetcher #(.FIFO_DEPTH(4), .ADDR_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .enable(enable),
    .start_addr(st), .end_addr(ea), .bus(bus),
    .sample_o(sample), .sample_valid_o(valid), .sample_ready_i(ready),
    .wrap_o(wrap), .underrun_o(urun)
`ifdef RAMBUS_TIMEOUT_EN
    , .timeout_o(tmo)
`endif
  );

  always #5 clk = ~clk;

  assign bus.rambus_wb_ack_i = bus.rambus_wb_cyc_o && !never_ack && (wait_cnt == dly);
  assign bus.rambus_wb_dat_i = ram[bus.rambus_wb_adr_o];

  always @(posedge clk) begin
    if (bus.rambus_wb_cyc_o && !bus.rambus_wb_ack_i) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Passive monitor: records accepted samples and acked addresses, checks per-cycle relations.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("wrap_o", wrap, prev_wrap_exp);
      chk("underrun_o", urun, enable && ready && !valid);
      chk("stb_eq_cyc", bus.rambus_wb_stb_o, bus.rambus_wb_cyc_o);
      chk("we_sel", {bus.rambus_wb_we_o, bus.rambus_wb_sel_o}, 5'h0F);
      prev_wrap_exp = bus.rambus_wb_cyc_o && bus.rambus_wb_ack_i && enable &&
                      (bus.rambus_wb_adr_o == ea);
      if (valid && ready) smp_q.push_back(sample);
      if (bus.rambus_wb_cyc_o && bus.rambus_wb_ack_i) adr_q.push_back(bus.rambus_wb_adr_o);
      if (urun) n_urun++;
    end
  end

  typedef struct {
    logic [7:0]  st;
    logic [7:0]  ea;
    int          dly;
    logic [39:0] adr;
    logic [95:0] smp;
    int          min_urun;
  } vec_t;

  vec_t vecs[4];

  task automatic clear_logs();
    smp_q.delete();
    adr_q.delete();
    n_urun = 0;
  endtask

  task automatic idle_off(input int n);
    enable = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    logic [39:0] ea_v;
    logic [95:0] es_v;
    int          guard;

    for (int a = 0; a < 256; a++)
      ram[a] = {8'(4*a+3), 8'(4*a+2), 8'(4*a+1), 8'(4*a)};
    ram[8'h10] = 32'h03020100;
    ram[8'h11] = 32'h07060504;

    vecs[0] = '{8'h10, 8'h11, 0, 40'h10_11_10_11_10, 96'h00_01_02_03_04_05_06_07_00_01_02_03, 0};
    vecs[1] = '{8'hFE, 8'h01, 0, 40'hFE_FF_00_01_FE, 96'hF8_F9_FA_FB_FC_FD_FE_FF_00_01_02_03, 0};
    vecs[2] = '{8'h10, 8'h11, 5, 40'h10_11_10_11_10, 96'h00_01_02_03_04_05_06_07_00_01_02_03, 1};
    vecs[3] = '{8'h20, 8'h20, 1, 40'h20_20_20_20_20, 96'h80_81_82_83_80_81_82_83_80_81_82_83, 0};

    // Reset state
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", bus.rambus_wb_cyc_o, 1'b0);
    chk("rst_adr", bus.rambus_wb_adr_o, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_underrun", urun, 1'b0);
    rst_n = 1'b1;
    step();
    mon_on = 1'b1;

    // Table-driven region runs with consumer always ready
    for (int v = 0; v < 4; v++) begin
      idle_off(4);
      st = vecs[v].st;
      ea = vecs[v].ea;
      dly = vecs[v].dly;
      ready = 1'b1;
      idle_off(2);
      clear_logs();
      enable = 1'b1;
      guard = 0;
      while ((smp_q.size() < 12 || adr_q.size() < 5) && guard < 600) begin
        step();
        guard++;
      end
      chk($sformatf("v%0d_budget", v), guard < 600, 1'b1);
      ea_v = vecs[v].adr;
      es_v = vecs[v].smp;
      for (int k = 0; k < 5; k++)
        chk($sformatf("v%0d_adr%0d", v, k), (k < adr_q.size()) ? adr_q[k] : 8'hxx,
            ea_v[8*(4-k) +: 8]);
      for (int k = 0; k < 12; k++)
        chk($sformatf("v%0d_smp%0d", v, k), (k < smp_q.size()) ? smp_q[k] : 8'hxx,
            es_v[8*(11-k) +: 8]);
      chk($sformatf("v%0d_underrun_seen", v), n_urun >= vecs[v].min_urun, 1'b1);
    end

    // Full boundary: consumer stalled, exactly FIFO_DEPTH fetches, then one pop -> one more
    idle_off(4);
    st = 8'h10; ea = 8'h11; dly = 0; ready = 1'b0;
    idle_off(2);
    clear_logs();
    enable = 1'b1;
    repeat (40) step();
    chk("full_acks", adr_q.size(), 4);
    chk("full_cyc_low", bus.rambus_wb_cyc_o, 1'b0);
    chk("full_valid", valid, 1'b1);
    chk("full_head", sample, 8'h00);
    ready = 1'b1;
    repeat (4) step();
    ready = 1'b0;
    repeat (30) step();
    chk("pop_samples", smp_q.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("pop_smp%0d", k), (k < smp_q.size()) ? smp_q[k] : 8'hxx, 8'(k));
    chk("pop_acks", adr_q.size(), 5);
    chk("pop_adr4", (adr_q.size() > 4) ? adr_q[4] : 8'hxx, 8'h10);

    // Enable dropped while a request is pending
    idle_off(4);
    dly = 3; ready = 1'b0;
    clear_logs();
    enable = 1'b1;
    guard = 0;
    while (adr_q.size() < 2 && guard < 100) begin step(); guard++; end
    chk("abort_prefill", adr_q.size(), 2);
    ready = 1'b1;
    step();
    ready = 1'b0;
    guard = 0;
    while (!(bus.rambus_wb_cyc_o && !bus.rambus_wb_ack_i) && guard < 20) begin step(); guard++; end
    chk("abort_req_seen", guard < 20, 1'b1);
    enable = 1'b0;
    guard = 0;
    while (!bus.rambus_wb_ack_i && guard < 20) begin
      chk("abort_cyc_held", bus.rambus_wb_cyc_o, 1'b1);
      step();
      guard++;
    end
    chk("abort_ack_seen", bus.rambus_wb_ack_i, 1'b1);
    repeat (3) step();
    chk("flush_valid", valid, 1'b0);
    chk("flush_cyc", bus.rambus_wb_cyc_o, 1'b0);
    chk("flush_adr", bus.rambus_wb_adr_o, 8'h10);
    dly = 0; ready = 1'b1;
    clear_logs();
    enable = 1'b1;
    guard = 0;
    while (smp_q.size() < 2 && guard < 100) begin step(); guard++; end
    chk("restart_adr", (adr_q.size() > 0) ? adr_q[0] : 8'hxx, 8'h10);
    chk("restart_smp0", (smp_q.size() > 0) ? smp_q[0] : 8'hxx, 8'h00);
    chk("restart_smp1", (smp_q.size() > 1) ? smp_q[1] : 8'hxx, 8'h01);

`ifdef RAMBUS_TIMEOUT_EN
    // Watchdog: no ack ever returns
    idle_off(4);
    never_ack = 1'b1; ready = 1'b0;
    chk("tmo_clear", tmo, 1'b0);
    enable = 1'b1;
    guard = 0;
    while (!bus.rambus_wb_cyc_o && guard < 10) begin step(); guard++; end
    guard = 0;
    while (bus.rambus_wb_cyc_o && guard < 400) begin step(); guard++; end
    chk("tmo_cycles", guard, 255);
    chk("tmo_flag", tmo, 1'b1);
    chk("tmo_adr", bus.rambus_wb_adr_o, 8'h10);
    idle_off(2);
    chk("tmo_cleared", tmo, 1'b0);
    never_ack = 1'b0;
`endif

    idle_off(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
